// File: rtl/alu_seq_pkg.sv
// alu_pkg: ALU control codes and FSM state type shared by the ALU and its control decoder
package alu_pkg;
    localparam logic [3:0] ALU_AND     = 4'h0;
    localparam logic [3:0] ALU_OR      = 4'h1;
    localparam logic [3:0] ALU_ADD     = 4'h2;
    localparam logic [3:0] ALU_MUL     = 4'h3;
    localparam logic [3:0] ALU_BNE     = 4'h5;
    localparam logic [3:0] ALU_SUB     = 4'h6;
    localparam logic [3:0] ALU_SLTU    = 4'h7;
    localparam logic [3:0] ALU_SLT     = 4'h8;
    localparam logic [3:0] ALU_SLL     = 4'h9;
    localparam logic [3:0] ALU_SLLV    = 4'hA;
    localparam logic [3:0] ALU_LUI     = 4'hB;
    localparam logic [3:0] ALU_ILLEGAL = 4'hF;
    typedef enum logic {IDLE, MUL} state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/completion bus between the issuing stage and the sequential ALU
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [4:0]       shamt_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;
    logic             illegal_o;
    modport master (output start_i, ctrl_i, src1_i, src2_i, shamt_i,
                    input ready_o, done_o, result_o, zero_o, overflow_o, illegal_o);
    modport slave (input start_i, ctrl_i, src1_i, src2_i, shamt_i,
                   output ready_o, done_o, result_o, zero_o, overflow_o, illegal_o);
endinterface

// File: rtl/alu_seq_mul_iter.sv
// mul_iter: iterative shift-add multiplier, one partial product per cycle, WIDTH cycles
module mul_iter #(parameter int WIDTH = 32) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    // accumulator plus this cycle's partial product; on the last step this is the product
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
        busy_o    = busy_q;
        product_o = acc_d;
    end
    // load operands on start, then shift-add until the counter hits the last bit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i && !busy_q) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            busy_q   <= !done_o;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: MIPS ALU with single-cycle ops and a multi-cycle MUL behind a ready/start/done handshake
module alu_seq
    import alu_pkg::*;
#(parameter int WIDTH = 32) (
    input logic       clk_i,
    input logic       rst_i,
    alu_seq_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, alu_res, sum, diff, mul_prod;
    logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d, done_q, done_d;
    logic             alu_zero, alu_ovf, alu_ill, mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] a, b;
    assign a = bus.src1_i;
    assign b = bus.src2_i;
    assign mul_start = (state_q == IDLE) && bus.start_i && (bus.ctrl_i == ALU_MUL);
    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(mul_start), .a_i(a), .b_i(b),
        .busy_o(mul_busy), .done_o(mul_done), .product_o(mul_prod)
    );
    // single-cycle datapath; BNE inverts the zero sense so branches test zero_o uniformly
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.ctrl_i)
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_ADD:  begin alu_res = sum; alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
            ALU_MUL:  alu_res = '0;
            ALU_BNE,
            ALU_SUB:  begin alu_res = diff; alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
            ALU_SLTU: alu_res = WIDTH'(a < b);
            ALU_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            ALU_SLL:  alu_res = b << bus.shamt_i;
            ALU_SLLV: alu_res = b << a[4:0];
            ALU_LUI:  alu_res = WIDTH'({b[15:0], 16'h0});
            default:  alu_ill = 1'b1;
        endcase
        alu_zero = (bus.ctrl_i == ALU_BNE) ? (alu_res != '0) : (alu_res == '0);
    end
    // handshake FSM: single-cycle ops complete from IDLE, MUL parks in MUL until the multiplier finishes
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: if (bus.start_i) begin
                if (bus.ctrl_i == ALU_MUL) state_d = MUL;
                else begin
                    done_d   = 1'b1;
                    result_d = alu_res;
                    zero_d   = alu_zero;
                    ovf_d    = alu_ovf;
                    ill_d    = alu_ill;
                end
            end
            MUL: if (mul_done) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = mul_prod;
                zero_d   = (mul_prod == '0);
                ovf_d    = 1'b0;
                ill_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers; zero_o resets high to agree with the cleared result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end
    assign bus.ready_o    = (state_q == IDLE);
    assign bus.done_o     = done_q;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = ovf_q;
    assign bus.illegal_o  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a scoreboard queue checked by an independent done_o monitor
module tb_alu_seq;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        v;
        logic        i;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    alu_seq_if #(.WIDTH(32)) bus();
    alu_seq #(.WIDTH(32)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [31:0] r, input logic z,
                         input logic v, input logic i);
        exp_t e;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.ctrl_i  = c;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.shamt_i = s;
        e.r = r; e.z = z; e.v = v; e.i = i;
        sb.push_back(e);
    endtask
    task automatic idle_inputs();
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ready"},    32'(bus.ready_o),    32'd1);
        chk({tag, " done"},     32'(bus.done_o),     32'd0);
        chk({tag, " result"},   bus.result_o,        32'd0);
        chk({tag, " zero"},     32'(bus.zero_o),     32'd1);
        chk({tag, " overflow"}, 32'(bus.overflow_o), 32'd0);
        chk({tag, " illegal"},  32'(bus.illegal_o),  32'd0);
    endtask
    // monitor: every done_o pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion, result %h", bus.result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",   bus.result_o,        e.r);
                chk("zero",     32'(bus.zero_o),     32'(e.z));
                chk("overflow", 32'(bus.overflow_o), 32'(e.v));
                chk("illegal",  32'(bus.illegal_o),  32'(e.i));
            end
        end
    end
    initial begin
        bus.start_i = 1'b0;
        bus.ctrl_i  = 4'h0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        bus.shamt_i = '0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'h2, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0);
        issue(4'h6, 32'h5,         32'h5,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0);
        issue(4'h5, 32'h5,         32'h5,         5'd0,  32'h0,         1'b0, 1'b0, 1'b0);
        issue(4'h8, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         1'b0, 1'b0, 1'b0);
        issue(4'h7, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0);
        issue(4'h9, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        issue(4'hB, 32'h0,         32'h1234,      5'd0,  32'h1234_0000, 1'b0, 1'b0, 1'b0);
        issue(4'h4, 32'h1,         32'h2,         5'd0,  32'h0,         1'b1, 1'b0, 1'b1);
        issue(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0, 1'b0);
        issue(4'h1, 32'h0F0F_0000, 32'h0000_00F0, 5'd0,  32'h0F0F_00F0, 1'b0, 1'b0, 1'b0);
        issue(4'h6, 32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue(4'hA, 32'h4,         32'h3,         5'd0,  32'h30,        1'b0, 1'b0, 1'b0);
        issue(4'hF, 32'h5,         32'h5,         5'd0,  32'h0,         1'b1, 1'b0, 1'b1);
        issue(4'h2, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0);
        issue(4'h3, 32'hFFFF_FFFF, 32'h3,         5'd0,  32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            chk($sformatf("mul_busy_ready[%0d]", k), 32'(bus.ready_o), 32'd0);
            bus.start_i = 1'b1;
            bus.ctrl_i  = 4'h2;
            bus.src1_i  = 32'h1111_1111 * (k + 1);
            bus.src2_i  = 32'h2;
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("mul_done_latency", 32'(bus.done_o), 32'd1);
        chk("mul_ready_back",   32'(bus.ready_o), 32'd1);
        issue(4'h3, 32'h1234_5678, 32'h9, 5'd0, 32'hA3D7_0A38, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        repeat (9) @(negedge clk);
        chk("abort_mul_busy", 32'(bus.ready_o), 32'd0);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_still_idle", 32'(bus.ready_o), 32'd1);
        issue(4'h2, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential ALU for the MIPS datapath, sitting directly downstream of the ALU control decoder: it consumes the 4-bit ALU control code plus the two register/immediate operands and produces the result, zero flag and overflow flag. Every operation except MUL completes in one cycle. MUL runs on an iterative shift-add multiplier, and a ready/start/done handshake stalls the issuing stage while it is busy.

## Interface
- `WIDTH`, default 32: datapath width; the MUL latency equals WIDTH cycles.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  issue request; sampled only when `ready_o`=1.
- `ctrl_i`  in  4  ALU control code.
- `src1_i`  in  WIDTH  operand A (rs).
- `src2_i`  in  WIDTH  operand B (rt or immediate).
- `shamt_i`  in  5  shift amount for SLL.
- `ready_o`  out  1  block can accept `start_i` this cycle.
- `done_o`  out  1  one-cycle pulse; `result_o` and the flags are valid.
- `result_o`  out  WIDTH  registered result; holds until the next completion.
- `zero_o`  out  1  branch-condition flag (see Operation).
- `overflow_o`  out  1  signed overflow for ADD/SUB.
- `illegal_o`  out  1  the accepted code was unsupported (pulses with `done_o`).

## Operation
- Control codes and the results they produce:
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 ADD: A+B.
  - 3 MUL: low WIDTH bits of A*B; the low word is identical for signed and unsigned operands.
  - 5 BNE: A−B; `zero_o` = (result≠0).
  - 6 SUB/BEQ: A−B; `zero_o` = (result==0).
  - 7 SLTU: unsigned A<B, result 1 or 0.
  - 8 SLT: signed A<B, result 1 or 0.
  - 9 SLL: B<<`shamt_i`.
  - 10 SLLV: B<<A[4:0].
  - 11 LUI: {B[15:0],16'h0}.
- Any other code, including 15:
  - `result_o`=0 and `illegal_o`=1.
  - Single-cycle completion.
- `zero_o`:
  - For codes other than 5, `zero_o` = (result==0).
  - For code 5 it is inverted, so downstream branch logic uses `zero_o` uniformly.
- `overflow_o`:
  - ADD: operands have the same sign and the result sign differs from them.
  - SUB/BNE: operands have different signs and the result sign differs from A.
  - All other codes: 0.
  - Overflow never suppresses the result write.
- States: IDLE and MUL.
  - IDLE, start_i=1, code≠3: compute combinationally, register result and flags, pulse `done_o`, stay in IDLE.
  - IDLE, start_i=1, code=3: latch the operands, clear the accumulator, counter=0, go to MUL.
  - MUL: each cycle, if multiplier bit0=1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right, and increment the counter.
  - MUL, counter reaches WIDTH−1: register the accumulator into `result_o`, pulse `done_o`, return to IDLE.
- `ready_o` = (state==IDLE).
- While busy, `start_i` and all operand and code inputs are ignored.
- Reset mid-MUL aborts the operation with no `done_o`; the state machine returns to IDLE.
- Reset values:
  - state IDLE and counter 0.
  - `result_o`=0 and `done_o`=0.
  - `zero_o`=1, which matches result=0.
  - `overflow_o`=0 and `illegal_o`=0.
  - `ready_o`=1 from reset assertion onwards.

## Timing
- Single-cycle ops: accepted at edge E0; `done_o`/`result_o` valid in the cycle after E0 (latency 1).
- Single-cycle ops issue back-to-back every cycle with a `done_o` every cycle.
- MUL: accepted at E0; `ready_o` is low from E0 through E(WIDTH).
- MUL: `done_o` is high in the cycle after E(WIDTH), i.e. latency WIDTH=32.
- MUL: `ready_o` is high again in the same cycle as `done_o`, so a new op may issue alongside the done pulse.
- `done_o` is exactly one cycle wide; `result_o` and the flags are stable until the next `done_o`.
- Every output is a flop output; there is no combinational path from the inputs to the outputs.

## Structure
- Package `alu_pkg`:
  - ALU control code constants (`ALU_AND`…`ALU_LUI`, `ALU_ILLEGAL`=4'hF); shared with the control decoder.
  - State enum `{IDLE, MUL}`.
- Sub-module `mul_iter`:
  - Shift-add multiplier with start/busy/done outputs, operand registers, accumulator and a $clog2(WIDTH) counter.
  - The top level holds the single-cycle datapath, the output registers and the handshake.

## Test plan
- ADD 0x7FFFFFFF+1 -> next cycle: result 0x80000000, `overflow_o`=1, `zero_o`=0, one `done_o`.
- SUB 5−5 then BNE 5−5, issued back-to-back -> two consecutive `done_o` pulses; `zero_o`=1 then 0.
- SLT 0xFFFFFFFF vs 1 -> result 1; SLTU on the same operands -> result 0.
- SLL B=0x1, shamt 31 -> 0x80000000; LUI B=0x1234 -> 0x12340000; code 4 -> result 0, `illegal_o`=1.
- MUL 0xFFFFFFFF×3 -> `ready_o` low for 32 cycles and `start_i` ignored while busy; `done_o` in cycle 33 with result 0xFFFFFFFD.
- MUL in progress, `rst_i` asserted at cycle 10 -> no `done_o`; all outputs at reset values; `ready_o`=1 immediately; the next ADD completes normally.
